dispense_sched: RTL and testbench

//  Round-robin scheduler sharing one coin/insert FSM pair among N_REQ requester ports (fsm_moore/fsm_mealy via module fsm).

---
 rtl/dsched_pkg.sv | 13 +
 rtl/dsched_rr_pick.sv | 28 ++
 rtl/dispense_sched.sv | 160 ++++++++++++++++
 tb/tb_dispense_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dsched_pkg.sv
// Shared types and helpers for the dispense scheduler.
package dsched_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE, ABORT} state_e;

    localparam logic [1:0] CA_DONE = 2'b11;

    // Timer must hold 0..timeout-1; keep at least one bit for tiny timeouts.
    function automatic int unsigned timer_width(input int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/dsched_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping mod N_REQ.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    logic [IW-1:0] cand;

    // Scan from the farthest offset down so the nearest match to ptr wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % N_REQ);
            if (req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dispense_sched.sv
// Round-robin scheduler sharing one coin/insert FSM among N_REQ requesters.
// Optional statistics counters are built when DSCHED_STATS_EN is defined.
module dispense_sched
    import dsched_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] c1_in,
    input  logic [N_REQ-1:0] c2_in,
    input  logic [N_REQ-1:0] i_in,
    input  logic [1:0]       fsm_ca,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] err,
    output logic             fsm_rst,
    output logic             fsm_c1,
    output logic             fsm_c2,
    output logic             fsm_i,
    output logic             busy,
    output logic [CNT_W-1:0] sess_cnt,
    output logic [CNT_W-1:0] abort_cnt
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned TW = timer_width(TIMEOUT);

    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d, idx_q, idx_d, pick_idx;
    logic             pick_valid;
    logic [TW-1:0]    timer_q, timer_d;
    logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d;
    logic             fsm_rst_q, fsm_rst_d, busy_q, busy_d;
    logic             c1_q, c1_d, c2_q, c2_d, i_q, i_d;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        gnt_d     = '0;
        done_d    = '0;
        err_d     = '0;
        fsm_rst_d = 1'b1;
        busy_d    = 1'b0;
        c1_d      = 1'b0;
        c2_d      = 1'b0;
        i_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    idx_d           = pick_idx;
                    timer_d         = '0;
                    state_d         = RUN;
                    gnt_d[pick_idx] = 1'b1;
                    busy_d          = 1'b1;
                    fsm_rst_d       = 1'b0;
                end
            end
            RUN: begin
                if (fsm_ca == CA_DONE) begin
                    state_d        = DONE;
                    done_d[idx_q]  = 1'b1;
                end else if (!req[idx_q] || timer_q == TW'(TIMEOUT - 1)) begin
                    state_d        = ABORT;
                    err_d[idx_q]   = 1'b1;
                end else begin
                    timer_d   = timer_q + 1'b1;
                    gnt_d     = gnt_q;
                    busy_d    = 1'b1;
                    fsm_rst_d = 1'b0;
                    c1_d      = c1_in[idx_q];
                    c2_d      = c2_in[idx_q];
                    i_d       = i_in[idx_q];
                end
            end
            DONE, ABORT: begin
                // The finished requester drops to lowest priority.
                ptr_d   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            fsm_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            c1_q      <= 1'b0;
            c2_q      <= 1'b0;
            i_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            fsm_rst_q <= fsm_rst_d;
            busy_q    <= busy_d;
            c1_q      <= c1_d;
            c2_q      <= c2_d;
            i_q       <= i_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign fsm_rst = fsm_rst_q;
    assign busy    = busy_q;
    assign fsm_c1  = c1_q;
    assign fsm_c2  = c2_q;
    assign fsm_i   = i_q;

`ifdef DSCHED_STATS_EN
    logic [CNT_W-1:0] sess_q, abort_q;

    // Counters move in the same cycle the done/err pulse appears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sess_q  <= '0;
            abort_q <= '0;
        end else begin
            if (|done_d && sess_q != '1) sess_q <= sess_q + 1'b1;
            if (|err_d && abort_q != '1) abort_q <= abort_q + 1'b1;
        end
    end

    assign sess_cnt  = sess_q;
    assign abort_cnt = abort_q;
`else
    assign sess_cnt  = '0;
    assign abort_cnt = '0;
`endif

endmodule

// File: tb/tb_dispense_sched.sv
// Randomized bench for dispense_sched against a session-level reference model.
module tb_dispense_sched;

    localparam int unsigned NR = 4;
    localparam int unsigned TO = 8;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req, c1_in, c2_in, i_in;
    logic [1:0]    fsm_ca, fk_ca;
    logic          ca_force;
    logic [NR-1:0] gnt, done, err;
    logic          fsm_rst, fsm_c1, fsm_c2, fsm_i, busy;
    logic [CW-1:0] sess_cnt, abort_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: owner of the session (-1 none), RUN age, idle gap, next start.
    int            m_owner = -1;
    int            m_age   = 0;
    int            m_gap   = 0;
    int            m_next  = 0;
    logic [NR-1:0] e_gnt = '0, e_done = '0, e_err = '0;
    logic          e_rst = 1'b1, e_busy = 1'b0, e_c1 = 1'b0, e_c2 = 1'b0, e_i = 1'b0;
    logic [CW-1:0] e_sess = '0, e_abort = '0;
    int            fk_st = 0;

    always #5 clk = ~clk;

    assign fk_ca  = (fk_st == 2) ? 2'b11 : ((fk_st == 1) ? 2'b01 : 2'b00);
    assign fsm_ca = ca_force ? 2'b11 : fk_ca;

    dispense_sched #(
        .N_REQ   (NR),
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .c1_in     (c1_in),
        .c2_in     (c2_in),
        .i_in      (i_in),
        .fsm_ca    (fsm_ca),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .fsm_rst   (fsm_rst),
        .fsm_c1    (fsm_c1),
        .fsm_c2    (fsm_c2),
        .fsm_i     (fsm_i),
        .busy      (busy),
        .sess_cnt  (sess_cnt),
        .abort_cnt (abort_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic end_session(input bit ok);
        if (ok) begin
            e_done[m_owner] = 1'b1;
`ifdef DSCHED_STATS_EN
            if (e_sess != '1) e_sess = e_sess + 1'b1;
`endif
        end else begin
            e_err[m_owner] = 1'b1;
`ifdef DSCHED_STATS_EN
            if (e_abort != '1) e_abort = e_abort + 1'b1;
`endif
        end
        m_next  = (m_owner + 1) % NR;
        m_owner = -1;
        m_gap   = 1;
    endtask

    // Advances the model by the clock edge that just passed, using the inputs seen at that edge.
    task automatic model_step();
        bit found;
        int p;
        e_done = '0;
        e_err  = '0;
        e_c1   = 1'b0;
        e_c2   = 1'b0;
        e_i    = 1'b0;
        if (!rst_n) begin
            m_owner = -1;
            m_age   = 0;
            m_gap   = 0;
            m_next  = 0;
            e_sess  = '0;
            e_abort = '0;
        end else if (m_owner >= 0) begin
            if (fsm_ca == 2'b11) end_session(1'b1);
            else if (!req[m_owner] || m_age == TO - 1) end_session(1'b0);
            else begin
                m_age++;
                e_c1 = c1_in[m_owner];
                e_c2 = c2_in[m_owner];
                e_i  = i_in[m_owner];
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            found = 1'b0;
            for (int k = 0; k < NR; k++) begin
                p = (m_next + k) % NR;
                if (!found && req[p]) begin
                    found   = 1'b1;
                    m_owner = p;
                    m_age   = 0;
                end
            end
        end
        e_gnt = '0;
        if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
        e_busy = (m_owner >= 0);
        e_rst  = (m_owner < 0);
    endtask

    // One clock: model update, full output compare, then the stand-in shared FSM reacts.
    task automatic cyc();
        @(negedge clk);
        model_step();
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("done", 32'(done), 32'(e_done));
        chk("err", 32'(err), 32'(e_err));
        chk("fsm_rst", 32'(fsm_rst), 32'(e_rst));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("fsm_c1", 32'(fsm_c1), 32'(e_c1));
        chk("fsm_c2", 32'(fsm_c2), 32'(e_c2));
        chk("fsm_i", 32'(fsm_i), 32'(e_i));
        chk("sess_cnt", 32'(sess_cnt), 32'(e_sess));
        chk("abort_cnt", 32'(abort_cnt), 32'(e_abort));
        if (fsm_rst) fk_st = 0;
        else if (fk_st == 0 && fsm_c1) fk_st = 1;
        else if (fk_st == 1 && fsm_c2) fk_st = 2;
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        c1_in    = '0;
        c2_in    = '0;
        i_in     = '0;
        ca_force = 1'b0;

        cyc();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_fsm_rst", 32'(fsm_rst), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);

        // Single session on port 0 completed by C1 then C2.
        rst_n = 1'b1;
        req   = 4'b0001;
        cyc();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_fsm_rst", 32'(fsm_rst), 32'h0);
        c1_in = 4'b0001;
        cyc();
        chk("t1_fwd_c1", 32'(fsm_c1), 32'h1);
        c1_in = '0;
        c2_in = 4'b0001;
        cyc();
        chk("t1_fwd_c2", 32'(fsm_c2), 32'h1);
        c2_in = '0;
        cyc();
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_done_rst", 32'(fsm_rst), 32'h1);
        chk("t1_done_gnt", 32'(gnt), 32'h0);
        req = '0;
        cyc();
        chk("t1_done_clear", 32'(done), 32'h0);

        // Timeout on port 2: abort decided on the eighth RUN cycle.
        req = 4'b0100;
        cyc();
        repeat (7) cyc();
        chk("t3_gnt_last", 32'(gnt), 32'h4);
        chk("t3_no_err_yet", 32'(err), 32'h0);
        cyc();
        chk("t3_err", 32'(err), 32'h4);
        chk("t3_busy", 32'(busy), 32'h0);
        req = 4'b1011;
        cyc();
        chk("t3_gap_rst", 32'(fsm_rst), 32'h1);
        chk("t3_gap_gnt", 32'(gnt), 32'h0);
        cyc();
        chk("t3_next_ptr3", 32'(gnt), 32'h8);

        // Withdrawal of the granted request aborts; grant then wraps to port 0.
        req = 4'b0011;
        cyc();
        chk("t4_err", 32'(err), 32'h8);
        chk("t4_busy", 32'(busy), 32'h0);
        cyc();
        cyc();
        chk("t4_next_gnt", 32'(gnt), 32'h1);

        // Completion and timeout in the same cycle: completion wins.
        repeat (7) cyc();
        ca_force = 1'b1;
        cyc();
        chk("t5_done", 32'(done), 32'h1);
        chk("t5_no_err", 32'(err), 32'h0);
`ifdef DSCHED_STATS_EN
        chk("t5_sess_cnt", 32'(sess_cnt), 32'd2);
        chk("t5_abort_cnt", 32'(abort_cnt), 32'd2);
`else
        chk("t5_sess_cnt", 32'(sess_cnt), 32'd0);
        chk("t5_abort_cnt", 32'(abort_cnt), 32'd0);
`endif
        ca_force = 1'b0;
        req      = 4'b0010;

        // Reset mid-session drops it silently and returns the pointer to 0.
        cyc();
        cyc();
        chk("t6_gnt_run", 32'(gnt), 32'h2);
        rst_n = 1'b0;
        cyc();
        chk("t6_gnt", 32'(gnt), 32'h0);
        chk("t6_done", 32'(done), 32'h0);
        chk("t6_err", 32'(err), 32'h0);
        chk("t6_fsm_rst", 32'(fsm_rst), 32'h1);
        rst_n = 1'b1;
        req   = 4'b1001;
        cyc();
        chk("t6_ptr0", 32'(gnt), 32'h1);

        for (int n = 0; n < 4000; n++) begin
            cyc();
            for (int i = 0; i < NR; i++) begin
                if (req[i] && (done[i] || err[i])) req[i] = 1'b0;
                else if (!req[i]) req[i] = ($urandom_range(0, 5) == 0);
                else if ($urandom_range(0, 99) == 0) req[i] = 1'b0;
                c1_in[i] = ($urandom_range(0, 3) == 0);
                c2_in[i] = ($urandom_range(0, 3) == 0);
                i_in[i]  = ($urandom_range(0, 1) == 0);
            end
            rst_n    = ($urandom_range(0, 299) != 0);
            ca_force = ($urandom_range(0, 39) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
